// File: rtl/fp_unrecode_sp_pipeline_pkg.sv
// rtl/fp_unrecode_sp_pipeline_pkg.sv - shared widths, constants and recoded-SP class decode
package fp_unrecode_sp_pipeline_pkg;

  localparam int FPR_RECODED_WIDTH   = 65;
  localparam int FPR_WIDTH           = 64;
  localparam int FPU_EXC_WIDTH       = 5;
  localparam int SP_RECODED_WIDTH    = 33;
  localparam int FPU_PIPE_UNRECODE_S = 2;

  localparam logic [8:0]  SP_REC_EXP_BIAS = 9'h081;
  localparam logic [31:0] SP_CANON_NAN    = 32'h7FC00000;
  localparam logic [31:0] SP_NAN_BOX      = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    REC_ZERO,
    REC_SUB,
    REC_NORM,
    REC_INF,
    REC_NAN
  } rec_class_e;

  // Top three recoded exponent bits carry the special-value class.
  function automatic rec_class_e rec_classify(input logic [8:0] rexp);
    rec_class_e c;
    case (rexp[8:6])
      3'b000:  c = REC_ZERO;
      3'b110:  c = REC_INF;
      3'b111:  c = REC_NAN;
      default: c = (rexp >= SP_REC_EXP_BIAS + 9'd1) ? REC_NORM : REC_SUB;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fp_unrecode_sp_pipeline_dec.sv
// rtl/fp_unrecode_sp_pipeline_dec.sv - combinational 33-bit recoded SP to IEEE binary32 decoder
module fp_unrecode_sp_pipeline_dec
  import fp_unrecode_sp_pipeline_pkg::*;
#(
  parameter bit CANON_NAN = 1'b0
) (
  input  logic [SP_RECODED_WIDTH-1:0] rec,
  output logic [31:0]                 ieee
);

  logic        sign;
  logic [8:0]  rexp;
  logic [22:0] sig;
  logic [8:0]  shift;

  assign sign  = rec[32];
  assign rexp  = rec[31:23];
  assign sig   = rec[22:0];
  assign shift = (SP_REC_EXP_BIAS + 9'd1) - rexp;

  always_comb begin
    ieee = '0;
    case (rec_classify(rexp))
      REC_ZERO: ieee = {sign, 8'h00, 23'h0};
      REC_INF:  ieee = {sign, 8'hFF, 23'h0};
      REC_NAN:  ieee = CANON_NAN ? SP_CANON_NAN : {sign, 8'hFF, sig | 23'h400000};
      // Low 8 bits suffice: the bias subtraction is exact modulo 256 for normals.
      REC_NORM: ieee = {sign, rexp[7:0] - 8'h81, sig};
      REC_SUB:  ieee = {sign, 8'h00, 23'(({1'b1, sig}) >> shift)};
      default:  ieee = '0;
    endcase
  end

endmodule

// File: rtl/fp_unrecode_sp_pipeline.sv
// rtl/fp_unrecode_sp_pipeline.sv - DEPTH-stage valid/ready pipeline unrecoding SP values to NaN-boxed binary32
module fp_unrecode_sp_pipeline
  import fp_unrecode_sp_pipeline_pkg::*;
#(
  parameter int unsigned DEPTH     = FPU_PIPE_UNRECODE_S,
  parameter bit          CANON_NAN = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [FPR_RECODED_WIDTH-1:0] in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [FPR_WIDTH-1:0]         result,
  output logic [FPU_EXC_WIDTH-1:0]     exc
);

  logic [31:0]      dec_ieee;
  logic [DEPTH-1:0] valid;
  logic [31:0]      data [DEPTH];
  logic [DEPTH:0]   adv;
  logic             unused_hi;

  assign unused_hi = ^in[FPR_RECODED_WIDTH-1:SP_RECODED_WIDTH];

  fp_unrecode_sp_pipeline_dec #(
    .CANON_NAN(CANON_NAN)
  ) u_dec (
    .rec (in[SP_RECODED_WIDTH-1:0]),
    .ieee(dec_ieee)
  );

  // A stage may advance if it or any stage downstream of it is empty, or the consumer takes the head.
  always_comb begin : adv_chain
    logic acc;
    acc        = out_ready;
    adv        = '0;
    adv[DEPTH] = out_ready;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      acc    = acc | ~valid[k];
      adv[k] = acc;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic        src_valid;
    logic [31:0] src_data;
    logic        valid_q;
    logic [31:0] data_q;

    if (k == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = dec_ieee;
    end else begin : g_body
      assign src_valid = valid[k-1];
      assign src_data  = data[k-1];
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (adv[k]) begin
        valid_q <= src_valid;
        data_q  <= src_data;
      end
    end

    assign valid[k] = valid_q;
    assign data[k]  = data_q;
  end

  assign in_ready  = adv[0];
  assign out_valid = valid[DEPTH-1];
  assign result    = {SP_NAN_BOX, data[DEPTH-1]};
  assign exc       = '0;

endmodule
